// File: rtl/bank_joltage_max_if.sv
// Stream interface for bank_joltage_max.
//   Input side : in_valid/in_ready handshake carrying in_digit (BCD) and in_last.
//   Output side: out_valid/out_ready handshake carrying out_value and out_err.
// The master modport is the producer of digits and consumer of results (the
// environment); the slave modport is the block itself.
interface bank_joltage_max_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_digit;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_value;
    logic              out_err;

    modport master (
        output in_valid,
        output in_digit,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_value,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_digit,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_value,
        output out_err
    );
endinterface

// File: rtl/bank_joltage_max.sv
// bank_joltage_max
// Consumes one battery bank per line as a stream of decimal digits and emits,
// per bank, the largest two-digit value formed by an ordered digit pair
// (tens digit earlier than units digit). Results are zero-extended to DATA_W
// and handed downstream over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; drops partial banks and any
//              pending result
//   bus        slave side of the digit/result stream interface
//   lines_done count of results handed off, wraps modulo 2^LINES_W
module bank_joltage_max #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter int LINES_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bank_joltage_max_if.slave  bus,
    output logic [LINES_W-1:0] lines_done
);

    // Illegal BCD codes (10..15) are folded to 0; the caller flags the line.
    function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd0;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic digit_illegal(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Per-line state
    logic [3:0]         best_first_q, best_first_d;
    logic [6:0]         best_pair_q,  best_pair_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               err_q,        err_d;
    // Output holding register
    logic               out_valid_q,  out_valid_d;
    logic [6:0]         out_value_q,  out_value_d;
    logic               out_err_q,    out_err_d;
    logic [LINES_W-1:0] lines_q,      lines_d;

    logic       in_ready_s;
    logic       accept_s;
    logic       out_hs_s;
    logic [3:0] digit_s;
    logic       bad_s;
    logic [6:0] cand_s;
    logic [6:0] pair_upd_s;
    logic [3:0] first_upd_s;

    // Handshake decode; in_ready never looks at in_valid.
    always_comb begin
        in_ready_s = !out_valid_q || bus.out_ready;
        accept_s   = bus.in_valid && in_ready_s;
        out_hs_s   = out_valid_q && bus.out_ready;
    end

    // Running best pair/first digit including the digit being offered now.
    // cand uses best_first before it absorbs this digit, so a digit never
    // pairs with itself.
    always_comb begin
        digit_s = sanitize_digit(bus.in_digit);
        bad_s   = digit_illegal(bus.in_digit);
        cand_s  = ({3'b000, best_first_q} * 7'd10) + {3'b000, digit_s};
        if ((cnt_q != {CNT_W{1'b0}}) && (cand_s > best_pair_q)) begin
            pair_upd_s = cand_s;
        end else begin
            pair_upd_s = best_pair_q;
        end
        if (digit_s > best_first_q) begin
            first_upd_s = digit_s;
        end else begin
            first_upd_s = best_first_q;
        end
    end

    // Next-state for line accumulation, output register and handoff counter.
    always_comb begin
        best_first_d = best_first_q;
        best_pair_d  = best_pair_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        out_value_d  = out_value_q;
        out_err_d    = out_err_q;
        lines_d      = lines_q;

        if (out_hs_s) begin
            lines_d     = lines_q + {{(LINES_W-1){1'b0}}, 1'b1};
            out_valid_d = 1'b0;
        end else begin
            lines_d = lines_q;
        end

        if (accept_s) begin
            if (bus.in_last) begin
                // A new result loading on the same edge as a handoff wins
                // over the deassert above, so out_valid stays high.
                out_valid_d  = 1'b1;
                out_value_d  = pair_upd_s;
                // Total digits < 2 exactly when this is the first one.
                out_err_d    = err_q || bad_s || (cnt_q == {CNT_W{1'b0}});
                best_first_d = 4'd0;
                best_pair_d  = 7'd0;
                cnt_d        = {CNT_W{1'b0}};
                err_d        = 1'b0;
            end else begin
                best_first_d = first_upd_s;
                best_pair_d  = pair_upd_s;
                err_d        = err_q || bad_s;
                if (cnt_q == {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            best_first_d = best_first_q;
        end
    end

    // State registers; reset discards partial banks and pending results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_first_q <= 4'd0;
            best_pair_q  <= 7'd0;
            cnt_q        <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_value_q  <= 7'd0;
            out_err_q    <= 1'b0;
            lines_q      <= {LINES_W{1'b0}};
        end else begin
            best_first_q <= best_first_d;
            best_pair_q  <= best_pair_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_err_q    <= out_err_d;
            lines_q      <= lines_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = {{(DATA_W-7){1'b0}}, out_value_q};
    assign bus.out_err   = out_err_q;
    assign lines_done    = lines_q;

endmodule

// File: doc/bank_joltage_max.md
Name: bank_joltage_max

Overview:
- Upstream feeder for the day-3 score accumulator.
- Consumes a stream of decimal digits, one battery bank (input line) at a time, terminated by a last flag.
- For each bank, finds the largest two-digit value formed by an ordered pair of digits (tens digit earlier in the line than units digit).
- Emits one DATA_W-bit zero-extended result per bank over a valid/ready handshake, ready to be summed downstream.

Parameters:
- DATA_W, 32, width of out_value; matches accumulator width.
- CNT_W, 8, width of the per-line digit counter; saturates at all-ones.
- LINES_W, 16, width of the lines_done counter; wraps.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_digit/in_last valid
- in_ready  output  1  block accepts a digit this cycle
- in_digit  input  4  BCD digit, legal range 0..9
- in_last  input  1  digit is the final one of the current bank
- out_valid  output  1  out_value/out_err hold a completed bank result
- out_ready  input  1  downstream consumes the result
- out_value  output  DATA_W  best pair value 0..99, zero-extended
- out_err  output  1  bank was malformed (see below)
- lines_done  output  LINES_W  count of results handed off (out_valid && out_ready)

Behaviour:
- Reset is asynchronous on rst_n low. All of the following clear immediately: out_valid=0, out_value=0, out_err=0, lines_done=0, and internal best_first, best_pair, digit count and line error flag.
- Reset asserted mid-line discards the partial bank. Reset asserted while a result is pending drops the result; it is never emitted.
- Input handshake: a digit is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready, with no dependence on in_valid.
- Per accepted digit d (an illegal d>9 is treated as 0 and sets the line error flag):
  - If digit count >= 1: cand = best_first*10 + d; best_pair = max(best_pair, cand).
  - best_first = max(best_first, d), evaluated after cand, so a digit never pairs with itself.
  - Digit count increments, saturating at 2^CNT_W-1.
- Arithmetic: best_first is 4 bits; cand and best_pair are 7 bits (max 99). Zero-extend to DATA_W only at the output.
- On an accepted digit with in_last=1:
  - On the next edge, out_valid=1, out_value=final best_pair (including this digit), out_err = line error flag OR (total digits < 2).
  - A bank with fewer than 2 digits outputs value 0, err 1.
  - Line state then clears: best_first=0, best_pair=0, count=0, error flag=0. The next accepted digit starts a new bank with no idle cycle.
- Latency: exactly 1 cycle from the last-digit handshake to out_valid.
- Output handshake:
  - out_value and out_err hold stable while out_valid && !out_ready.
  - out_valid deasserts the cycle after a handshake unless a new result loads on that same edge.
- Simultaneous handoff and last-digit accept in one cycle: out_valid stays 1 with the new result loaded, and lines_done still increments.
- Stall: while out_valid && !out_ready, no digits are accepted, including non-last digits. Line state is frozen.
- lines_done increments by 1 per output handshake and wraps modulo 2^LINES_W.
- An in_valid=0 gap mid-line is legal. State holds, and the result is unaffected.

Test Plan:
- Feed banks "987654321111111", "811111111111119", "234234234234278", "818181911112111" with out_ready=1 -> results 98, 89, 78, 92 (sum 357), all out_err=0; lines_done=4; each out_valid exactly 1 cycle after its last digit.
- Single-digit bank "5" with last -> out_value=0, out_err=1. Following bank "12" -> 12, err=0 (no state leakage).
- Bank "1A3" (digit 0xA mid-line) -> value 13 (A taken as 0, best of 10/13/03), out_err=1.
- Complete "91" with out_ready=0 for 3 cycles -> out_value=91 held stable, in_ready=0 throughout, next bank's digits not consumed. Raise out_ready -> handoff, lines_done+1.
- Back-to-back banks "19","55" with out_ready=1 and last digits on consecutive-bank boundaries -> out_valid stays high across the overlap cycle, values 19 then 55, no bubble or drop.
- Pull rst_n low after "98" of bank "987" (no last) and while a prior result is pending -> outputs clear immediately. After release, bank "34" -> single result 34, lines_done=1.
